// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one inverse round per clock.
// Optional rk10 cache, enabled by defining AES_DEC_KEY_CACHE_EN, skips key expansion on a repeated key.
module aes128_decrypt_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StFinal} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] blk_q;
  logic [127:0] key_q;
  logic [127:0] key0_q;
`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_vld_q;
  logic [127:0] cache_key_q;
  logic [127:0] cache_rk_q;
`endif

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = gf_inv(x);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] inv_mix_coef(input int k);
    case (k & 3)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [31:0] res;
    logic [7:0]  acc;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul(inv_mix_coef(j - r), col[31-8*j -: 8]);
      end
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  logic [7:0]   rcon;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  b0, b1, b2, b3;
  logic [127:0] key_fwd;
  logic [127:0] key_bwd;
  logic [127:0] inv_sb;
  logic [127:0] mixed_in;
  logic [127:0] round_out;

  // Both key directions use Rcon of round cnt+1: forward builds rk[cnt+1], backward undoes it.
  always_comb begin
    rcon = rcon_f(cnt_q + 4'd1);
    f0 = key_q[127:96] ^ sub_rot_word(key_q[31:0]) ^ {rcon, 24'h0};
    f1 = key_q[95:64] ^ f0;
    f2 = key_q[63:32] ^ f1;
    f3 = key_q[31:0] ^ f2;
    key_fwd = {f0, f1, f2, f3};
    b3 = key_q[31:0] ^ key_q[63:32];
    b2 = key_q[63:32] ^ key_q[95:64];
    b1 = key_q[95:64] ^ key_q[127:96];
    b0 = key_q[127:96] ^ sub_rot_word(b3) ^ {rcon, 24'h0};
    key_bwd = {b0, b1, b2, b3};
  end

  // InvShiftRows moves row r right by r columns; fused with InvSubBytes.
  always_comb begin
    inv_sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_sb[127-8*(4*c+r) -: 8] = inv_sbox(blk_q[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    mixed_in  = inv_sb ^ key_bwd;
    round_out = '0;
    for (int c = 0; c < 4; c++) begin
      round_out[127-32*c -: 32] = inv_mix_col(mixed_in[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= StIdle;
      cnt_q       <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      key0_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_out    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            blk_q  <= data_in;
            key_q  <= key_in;
            key0_q <= key_in;
            cnt_q  <= '0;
            busy   <= 1'b1;
            fsm_q  <= StKeyExp;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_vld_q && (key_in == cache_key_q)) begin
              key_q <= cache_rk_q;
              fsm_q <= StInit;
            end
`endif
          end
        end
        StKeyExp: begin
          key_q <= key_fwd;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) fsm_q <= StInit;
        end
        StInit: begin
          blk_q <= blk_q ^ key_q;
          cnt_q <= 4'd9;
          fsm_q <= StRound;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_vld_q <= 1'b1;
          cache_key_q <= key0_q;
          cache_rk_q  <= key_q;
`endif
        end
        StRound: begin
          key_q <= key_bwd;
          blk_q <= round_out;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) fsm_q <= StFinal;
        end
        StFinal: begin
          data_out <= inv_sb ^ key0_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          cnt_q    <= '0;
          fsm_q    <= StIdle;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Testbench for aes128_decrypt_core: FIPS-197 vectors plus random blocks against a byte-array model.
// Latency expectations follow AES_DEC_KEY_CACHE_EN when the build defines it.
module tb_aes128_decrypt_core;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic         start   = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in  = '0;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes128_decrypt_core dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .key_in  (key_in),
    .busy    (busy),
    .done    (done),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];
  bit         cache_vld = 1'b0;
  logic [127:0] cache_key = '0;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // p walks the multiplicative group by 3, q tracks its inverse.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = i[7:0];
  endtask

  function automatic logic [7:0] mulc(input logic [7:0] a, input int c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    case (c)
      9:       return x8 ^ a;
      11:      return x8 ^ x2 ^ a;
      13:      return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ w[40 + j/4][31-8*(j%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[4*c+r] = inv_t[s[4*((c-r+4)%4)+r]];
      for (int j = 0; j < 16; j++) s[j] = u[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mulc(a0, 14) ^ mulc(a1, 11) ^ mulc(a2, 13) ^ mulc(a3, 9);
          s[4*c+1] = mulc(a0, 9)  ^ mulc(a1, 14) ^ mulc(a2, 11) ^ mulc(a3, 13);
          s[4*c+2] = mulc(a0, 13) ^ mulc(a1, 9)  ^ mulc(a2, 14) ^ mulc(a3, 11);
          s[4*c+3] = mulc(a0, 11) ^ mulc(a1, 13) ^ mulc(a2, 9)  ^ mulc(a3, 14);
        end
      end
    end
    res = '0;
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    return (CacheEn && cache_vld && (k == cache_key)) ? 11 : 21;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus driver (no checks) ----------------
  int           op_lat;
  bit           op_busy_ok;
  logic [127:0] op_rk_init;
  time          op_done_t;

  task automatic do_op(input logic [127:0] k, input logic [127:0] d, input bit hold);
    @(negedge clk);
    key_in  = k;
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    op_busy_ok = (busy === 1'b1) && (done === 1'b0);
    op_lat     = -1;
    op_rk_init = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) op_rk_init = dut.key_q;
      if (done === 1'b1) begin
        if (busy !== 1'b0) op_busy_ok = 1'b0;
        op_lat    = n;
        op_done_t = $time;
        break;
      end
      if (busy !== 1'b1) op_busy_ok = 1'b0;
    end
    cache_vld = 1'b1;
    cache_key = k;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (data_out !== 128'h0) begin
      n_fails++; $display("FAIL reset_data_out: got %h want 0", data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fails++; $display("FAIL idle_quiet: busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_fips_c1();
    int el;
    el = exp_lat(K_C1);
    do_op(K_C1, CT_C1, 1'b0);
    n_checks++;
    if (op_lat !== el) begin n_fails++; $display("FAIL c1_latency: got %0d want %0d", op_lat, el); end
    n_checks++;
    if (data_out !== PT_C1) begin
      n_fails++; $display("FAIL c1_data: got %h want %h", data_out, PT_C1);
    end
    n_checks++;
    if (!op_busy_ok) begin n_fails++; $display("FAIL c1_busy: got bad busy/done overlap, want clean"); end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || data_out !== PT_C1) begin
      n_fails++; $display("FAIL c1_hold: done %b data %h want 0 %h", done, data_out, PT_C1);
    end
  endtask

  task automatic test_fips_b();
    int el;
    el = exp_lat(K_B);
    do_op(K_B, CT_B, 1'b0);
    n_checks++;
    if (op_lat !== el) begin n_fails++; $display("FAIL b_latency: got %0d want %0d", op_lat, el); end
    n_checks++;
    if (op_rk_init !== RK10_B) begin
      n_fails++; $display("FAIL b_rk10: got %h want %h", op_rk_init, RK10_B);
    end
    n_checks++;
    if (data_out !== PT_B) begin
      n_fails++; $display("FAIL b_data: got %h want %h", data_out, PT_B);
    end
  endtask

  task automatic test_busy_ignore();
    int  el;
    int  lat;
    bit  ok;
    el = exp_lat(K_C1);
    @(negedge clk);
    key_in = K_C1; data_in = CT_C1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ok  = (busy === 1'b1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (busy !== 1'b0) ok = 1'b0;
        lat = n;
        break;
      end
      if (busy !== 1'b1) ok = 1'b0;
      if (n >= 3 && n <= 8) begin
        start = 1'b1; data_in = rand128(); key_in = rand128();
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    cache_vld = 1'b1;
    cache_key = K_C1;
    n_checks++;
    if (lat !== el) begin n_fails++; $display("FAIL ignore_latency: got %0d want %0d", lat, el); end
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL ignore_busy: got early busy drop, want held"); end
    n_checks++;
    if (data_out !== PT_C1) begin
      n_fails++; $display("FAIL ignore_data: got %h want %h", data_out, PT_C1);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, d;
    k = rand128();
    d = rand128();
    @(negedge clk);
    key_in = k; data_in = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fails++; $display("FAIL midreset_ctrl: busy %b done %b want 0 0", busy, done);
    end
    n_checks++;
    if (data_out !== 128'h0) begin
      n_fails++; $display("FAIL midreset_data: got %h want 0", data_out);
    end
    n_checks++;
    if (dut.key_q !== 128'h0) begin
      n_fails++; $display("FAIL midreset_key: got %h want 0", dut.key_q);
    end
    cache_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    k = rand128();
    d = rand128();
    do_op(k, d, 1'b0);
    n_checks++;
    if (op_lat !== 21) begin n_fails++; $display("FAIL postreset_latency: got %0d want 21", op_lat); end
    n_checks++;
    if (data_out !== ref_decrypt(k, d)) begin
      n_fails++; $display("FAIL postreset_data: got %h want %h", data_out, ref_decrypt(k, d));
    end
  endtask

  task automatic test_back_to_back();
    int  el1, el2;
    time t1;
    el1 = exp_lat(K_C1);
    do_op(K_C1, CT_C1, 1'b1);
    t1 = op_done_t;
    n_checks++;
    if (op_lat !== el1 || data_out !== PT_C1) begin
      n_fails++; $display("FAIL b2b_first: lat %0d data %h want %0d %h", op_lat, data_out, el1, PT_C1);
    end
    el2 = exp_lat(K_B);
    do_op(K_B, CT_B, 1'b1);
    start = 1'b0;
    n_checks++;
    if (data_out !== PT_B || !op_busy_ok) begin
      n_fails++; $display("FAIL b2b_second: data %h busy_ok %b want %h 1", data_out, op_busy_ok, PT_B);
    end
    n_checks++;
    if (op_lat < 0 || (op_done_t - t1) / 10 !== 64'(1 + el2)) begin
      n_fails++; $display("FAIL b2b_gap: got %0d cycles want %0d", (op_done_t - t1) / 10, 1 + el2);
    end
  endtask

  task automatic test_cache();
    int el;
    for (int i = 0; i < 3; i++) begin
      logic [127:0] k, d, p;
      k = (i < 2) ? K_C1 : K_B;
      d = (i < 2) ? CT_C1 : CT_B;
      p = (i < 2) ? PT_C1 : PT_B;
      el = exp_lat(k);
      do_op(k, d, 1'b0);
      n_checks++;
      if (op_lat !== el) begin
        n_fails++; $display("FAIL cache_latency[%0d]: got %0d want %0d", i, op_lat, el);
      end
      n_checks++;
      if (data_out !== p) begin
        n_fails++; $display("FAIL cache_data[%0d]: got %h want %h", i, data_out, p);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] k, d, exp;
    int el;
    k = rand128();
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) k = rand128();
      d   = rand128();
      exp = ref_decrypt(k, d);
      el  = exp_lat(k);
      do_op(k, d, 1'b0);
      n_checks++;
      if (op_lat !== el) begin
        n_fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, op_lat, el);
      end
      n_checks++;
      if (data_out !== exp) begin
        n_fails++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_out, exp);
      end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_cache();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
